mini_src_control_unit: RTL and testbench

Hardwired Moore sequencer for the Mini-SRC 32-bit datapath. It runs fetch, decode and execute by driving the datapath's bus-read selects, register write enables, register-file location and ALU opcode. It owns the memory request/ready handshake used by the MDR and MAR. It sits beside the datapath and reads IR contents back from the datapath's IR register output.

---
 rtl/mini_src_control_unit_pkg.sv | 75 +++++++
 rtl/mini_src_control_unit_decode.sv | 46 ++++
 rtl/mini_src_control_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mini_src_control_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_control_unit_pkg.sv
// Shared definitions for the Mini-SRC control unit.
// Holds the instruction opcodes, ALU operation codes, sequencer state encodings
// and instruction class encodings used by mini_src_decode and mini_src_control_unit.
package mini_src_control_unit_pkg;

  localparam int OPCODE_W = 5;
  localparam int ALU_OP_W = 4;

  // Instruction opcodes (IR[31:27])
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b10100;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_ROL = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_NEG = 4'hA;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'hB;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 4'hC;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_F3   = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_E3   = 4'd8,
    S_E4   = 4'd9,
    S_HALT = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_IMM     = 4'd1,
    C_UNARY   = 4'd2,
    C_MULDIV  = 4'd3,
    C_MFHI    = 4'd4,
    C_MFLO    = 4'd5,
    C_LD      = 4'd6,
    C_ST      = 4'd7,
    C_NOP     = 4'd8,
    C_HALT    = 4'd9,
    C_ILLEGAL = 4'd10
  } iclass_e;

endpackage

// File: rtl/mini_src_control_unit_decode.sv
// mini_src_decode: combinational opcode decoder.
// Ports:
//   opcode  in   IR[31:27]
//   iclass  out  instruction class steering the execute sequence
//   alu_op  out  ALU operation used by the instruction's compute step
module mini_src_decode
  import mini_src_control_unit_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_e             iclass,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   begin iclass = C_LD;     alu_op = ALU_ADD; end
      OP_ST:   begin iclass = C_ST;     alu_op = ALU_ADD; end
      OP_ADD:  begin iclass = C_RTYPE;  alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = C_RTYPE;  alu_op = ALU_SUB; end
      OP_AND:  begin iclass = C_RTYPE;  alu_op = ALU_AND; end
      OP_OR:   begin iclass = C_RTYPE;  alu_op = ALU_OR;  end
      OP_SHR:  begin iclass = C_RTYPE;  alu_op = ALU_SHR; end
      OP_SHL:  begin iclass = C_RTYPE;  alu_op = ALU_SHL; end
      OP_ROR:  begin iclass = C_RTYPE;  alu_op = ALU_ROR; end
      OP_ROL:  begin iclass = C_RTYPE;  alu_op = ALU_ROL; end
      OP_ADDI: begin iclass = C_IMM;    alu_op = ALU_ADD; end
      OP_ANDI: begin iclass = C_IMM;    alu_op = ALU_AND; end
      OP_ORI:  begin iclass = C_IMM;    alu_op = ALU_OR;  end
      OP_MUL:  begin iclass = C_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin iclass = C_MULDIV; alu_op = ALU_DIV; end
      OP_NEG:  begin iclass = C_UNARY;  alu_op = ALU_NEG; end
      OP_NOT:  begin iclass = C_UNARY;  alu_op = ALU_NOT; end
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_NOP:  iclass = C_NOP;
      OP_HALT: iclass = C_HALT;
      default: begin
        iclass = C_ILLEGAL;
        alu_op = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// mini_src_control_unit: hardwired Moore sequencer for the Mini-SRC datapath.
// Runs fetch/decode/execute by driving bus selects, register loads, the
// register-file index and the ALU opcode, and owns the memory handshake.
// Ports:
//   clk, in_clr              clock / async active-high reset
//   in_run                   leave IDLE and start fetching
//   in_ir                    IR contents read back from the datapath
//   in_mem_ready             memory finishes the outstanding request
//   out_regfile_location     register-file index
//   out_alu_opcode           ALU operation
//   out_*_read               bus source selects (one-hot or none)
//   out_*_write              register loads
//   out_mdr_select           1 = MDR loads from memory
//   out_mem_req, out_mem_we  memory request / write qualifier
//   out_halted, out_illegal  status
//
// state | meaning
// IDLE  | waiting for in_run, all outputs low
// F0    | PC -> MAR, Z <- PC+1
// F1    | Z -> PC
// F2    | memory read into MDR, held until in_mem_ready
// F3    | MDR -> IR
// E0-E4 | execute steps, sequence chosen by instruction class
// HALT  | stopped until in_clr
module mini_src_control_unit
  import mini_src_control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                in_clr,
  input  logic                in_run,
  input  logic [31:0]         in_ir,
  input  logic                in_mem_ready,
  output logic [3:0]          out_regfile_location,
  output logic [ALU_OP_W-1:0] out_alu_opcode,
  output logic                out_regfile_read,
  output logic                out_hi_read,
  output logic                out_lo_read,
  output logic                out_z_hi_read,
  output logic                out_z_lo_read,
  output logic                out_pc_read,
  output logic                out_mdr_read,
  output logic                out_inport_read,
  output logic                out_c_read,
  output logic                out_regfile_write,
  output logic                out_hi_write,
  output logic                out_lo_write,
  output logic                out_z_write,
  output logic                out_pc_write,
  output logic                out_mdr_write,
  output logic                out_ir_write,
  output logic                out_y_write,
  output logic                out_mar_write,
  output logic                out_mdr_select,
  output logic                out_mem_req,
  output logic                out_mem_we,
  output logic                out_halted,
  output logic                out_illegal
);

  state_e              state;
  state_e              next_state;
  iclass_e             iclass;
  logic [ALU_OP_W-1:0] dec_alu;
  logic [3:0]          ra;
  logic [3:0]          rb;
  logic [3:0]          rc;
  logic                unused_ir;

  assign ra = in_ir[26:23];
  assign rb = in_ir[22:19];
  assign rc = in_ir[18:15];
  // Immediate bits feed the datapath's C register directly.
  assign unused_ir = ^in_ir[14:0];

  mini_src_decode u_decode (
    .opcode (in_ir[31 -: OPCODE_W]),
    .iclass (iclass),
    .alu_op (dec_alu)
  );

  always_ff @(posedge clk or posedge in_clr) begin
    if (in_clr) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state           = state;
    out_regfile_location = 4'd0;
    out_alu_opcode       = ALU_ADD;
    out_regfile_read     = 1'b0;
    out_hi_read          = 1'b0;
    out_lo_read          = 1'b0;
    out_z_hi_read        = 1'b0;
    out_z_lo_read        = 1'b0;
    out_pc_read          = 1'b0;
    out_mdr_read         = 1'b0;
    out_inport_read      = 1'b0;
    out_c_read           = 1'b0;
    out_regfile_write    = 1'b0;
    out_hi_write         = 1'b0;
    out_lo_write         = 1'b0;
    out_z_write          = 1'b0;
    out_pc_write         = 1'b0;
    out_mdr_write        = 1'b0;
    out_ir_write         = 1'b0;
    out_y_write          = 1'b0;
    out_mar_write        = 1'b0;
    out_mdr_select       = 1'b0;
    out_mem_req          = 1'b0;
    out_mem_we           = 1'b0;
    out_halted           = 1'b0;
    out_illegal          = 1'b0;

    case (state)
      S_IDLE: if (in_run) next_state = S_F0;

      S_F0: begin
        out_pc_read    = 1'b1;
        out_mar_write  = 1'b1;
        out_alu_opcode = ALU_INC;
        out_z_write    = 1'b1;
        next_state     = S_F1;
      end

      S_F1: begin
        out_z_lo_read = 1'b1;
        out_pc_write  = 1'b1;
        next_state    = S_F2;
      end

      // MDR captures the read data in the same cycle memory reports ready.
      S_F2: begin
        out_mem_req    = 1'b1;
        out_mdr_select = 1'b1;
        out_mdr_write  = in_mem_ready;
        if (in_mem_ready) next_state = S_F3;
      end

      S_F3: begin
        out_mdr_read = 1'b1;
        out_ir_write = 1'b1;
        next_state   = S_E0;
      end

      S_E0: begin
        case (iclass)
          C_RTYPE, C_IMM, C_MULDIV, C_LD, C_ST: begin
            out_regfile_location = rb;
            out_regfile_read     = 1'b1;
            out_y_write          = 1'b1;
            next_state           = S_E1;
          end
          C_UNARY: begin
            out_regfile_location = rb;
            out_regfile_read     = 1'b1;
            out_alu_opcode       = dec_alu;
            out_z_write          = 1'b1;
            next_state           = S_E1;
          end
          C_MFHI, C_MFLO: begin
            out_hi_read          = (iclass == C_MFHI);
            out_lo_read          = (iclass == C_MFLO);
            out_regfile_location = ra;
            out_regfile_write    = 1'b1;
            next_state           = S_F0;
          end
          C_HALT:    next_state = S_HALT;
          C_ILLEGAL: begin
            out_illegal = 1'b1;
            next_state  = S_F0;
          end
          default:   next_state = S_F0;
        endcase
      end

      S_E1: begin
        next_state = S_E2;
        case (iclass)
          C_RTYPE, C_MULDIV: begin
            out_regfile_location = rc;
            out_regfile_read     = 1'b1;
            out_alu_opcode       = dec_alu;
            out_z_write          = 1'b1;
          end
          C_IMM, C_LD, C_ST: begin
            out_c_read     = 1'b1;
            out_alu_opcode = dec_alu;
            out_z_write    = 1'b1;
          end
          C_UNARY: begin
            out_z_lo_read        = 1'b1;
            out_regfile_location = ra;
            out_regfile_write    = 1'b1;
            next_state           = S_F0;
          end
          default: next_state = S_F0;
        endcase
      end

      S_E2: begin
        next_state    = S_E3;
        out_z_lo_read = 1'b1;
        case (iclass)
          C_RTYPE, C_IMM: begin
            out_regfile_location = ra;
            out_regfile_write    = 1'b1;
            next_state           = S_F0;
          end
          C_MULDIV:   out_lo_write  = 1'b1;
          C_LD, C_ST: out_mar_write = 1'b1;
          default: begin
            out_z_lo_read = 1'b0;
            next_state    = S_F0;
          end
        endcase
      end

      S_E3: begin
        case (iclass)
          C_MULDIV: begin
            out_z_hi_read = 1'b1;
            out_hi_write  = 1'b1;
            next_state    = S_F0;
          end
          C_LD: begin
            out_mem_req    = 1'b1;
            out_mdr_select = 1'b1;
            out_mdr_write  = in_mem_ready;
            if (in_mem_ready) next_state = S_E4;
          end
          // Store data goes register -> bus -> MDR before the write request.
          C_ST: begin
            out_regfile_location = ra;
            out_regfile_read     = 1'b1;
            out_mdr_write        = 1'b1;
            next_state           = S_E4;
          end
          default: next_state = S_F0;
        endcase
      end

      S_E4: begin
        case (iclass)
          C_LD: begin
            out_mdr_read         = 1'b1;
            out_regfile_location = ra;
            out_regfile_write    = 1'b1;
            next_state           = S_F0;
          end
          C_ST: begin
            out_mem_req = 1'b1;
            out_mem_we  = 1'b1;
            if (in_mem_ready) next_state = S_F0;
          end
          default: next_state = S_F0;
        endcase
      end

      S_HALT: out_halted = 1'b1;

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
module tb_mini_src_control_unit;

  typedef struct packed {
    logic [3:0] loc;
    logic [3:0] alu;
    logic rf_rd, hi_rd, lo_rd, zh_rd, zl_rd, pc_rd, mdr_rd, in_rd, c_rd;
    logic rf_wr, hi_wr, lo_wr, z_wr, pc_wr, mdr_wr, ir_wr, y_wr, mar_wr;
    logic mdr_sel, mem_req, mem_we, halted, illegal;
  } obs_t;

  logic        clk;
  logic        in_clr;
  logic        in_run;
  logic [31:0] in_ir;
  logic        in_mem_ready;
  logic [3:0]  out_regfile_location;
  logic [3:0]  out_alu_opcode;
  logic out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read;
  logic out_pc_read, out_mdr_read, out_inport_read, out_c_read;
  logic out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write;
  logic out_mdr_write, out_ir_write, out_y_write, out_mar_write;
  logic out_mdr_select, out_mem_req, out_mem_we, out_halted, out_illegal;

  mini_src_control_unit dut (
    .clk                  (clk),
    .in_clr               (in_clr),
    .in_run               (in_run),
    .in_ir                (in_ir),
    .in_mem_ready         (in_mem_ready),
    .out_regfile_location (out_regfile_location),
    .out_alu_opcode       (out_alu_opcode),
    .out_regfile_read     (out_regfile_read),
    .out_hi_read          (out_hi_read),
    .out_lo_read          (out_lo_read),
    .out_z_hi_read        (out_z_hi_read),
    .out_z_lo_read        (out_z_lo_read),
    .out_pc_read          (out_pc_read),
    .out_mdr_read         (out_mdr_read),
    .out_inport_read      (out_inport_read),
    .out_c_read           (out_c_read),
    .out_regfile_write    (out_regfile_write),
    .out_hi_write         (out_hi_write),
    .out_lo_write         (out_lo_write),
    .out_z_write          (out_z_write),
    .out_pc_write         (out_pc_write),
    .out_mdr_write        (out_mdr_write),
    .out_ir_write         (out_ir_write),
    .out_y_write          (out_y_write),
    .out_mar_write        (out_mar_write),
    .out_mdr_select       (out_mdr_select),
    .out_mem_req          (out_mem_req),
    .out_mem_we           (out_mem_we),
    .out_halted           (out_halted),
    .out_illegal          (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  act;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always_comb begin
    act         = '0;
    act.loc     = out_regfile_location;
    act.alu     = out_alu_opcode;
    act.rf_rd   = out_regfile_read;
    act.hi_rd   = out_hi_read;
    act.lo_rd   = out_lo_read;
    act.zh_rd   = out_z_hi_read;
    act.zl_rd   = out_z_lo_read;
    act.pc_rd   = out_pc_read;
    act.mdr_rd  = out_mdr_read;
    act.in_rd   = out_inport_read;
    act.c_rd    = out_c_read;
    act.rf_wr   = out_regfile_write;
    act.hi_wr   = out_hi_write;
    act.lo_wr   = out_lo_write;
    act.z_wr    = out_z_write;
    act.pc_wr   = out_pc_write;
    act.mdr_wr  = out_mdr_write;
    act.ir_wr   = out_ir_write;
    act.y_wr    = out_y_write;
    act.mar_wr  = out_mar_write;
    act.mdr_sel = out_mdr_select;
    act.mem_req = out_mem_req;
    act.mem_we  = out_mem_we;
    act.halted  = out_halted;
    act.illegal = out_illegal;
  end

  // Monitor: pops one expected output vector per cycle that has one queued,
  // and checks the one-bus-driver invariant every cycle.
  always @(negedge clk) begin
    obs_t  e;
    string t;
    int    nsel;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", t, act, e, $time);
      end
    end
    nsel = $countones({out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read,
                       out_z_lo_read, out_pc_read, out_mdr_read, out_inport_read,
                       out_c_read});
    checks++;
    if (nsel > 1) begin
      errors++;
      $display("FAIL bus_select_onehot: got %0d selects expected at most 1 (t=%0t)", nsel, $time);
    end
  end

  task automatic cyc(input obs_t e, input logic rdy, input string tag);
    in_mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc('0, 1'b1, tag);
  endtask

  task automatic fetch(input int waits);
    obs_t e;
    e = '0; e.pc_rd = 1; e.mar_wr = 1; e.alu = 4'hC; e.z_wr = 1;
    cyc(e, 1'b1, "F0");
    e = '0; e.zl_rd = 1; e.pc_wr = 1;
    cyc(e, 1'b1, "F1");
    for (int i = 0; i < waits; i++) begin
      e = '0; e.mem_req = 1; e.mdr_sel = 1;
      cyc(e, 1'b0, "F2_wait");
    end
    e = '0; e.mem_req = 1; e.mdr_sel = 1; e.mdr_wr = 1;
    cyc(e, 1'b1, "F2_ready");
    e = '0; e.mdr_rd = 1; e.ir_wr = 1;
    cyc(e, 1'b1, "F3");
  endtask

  task automatic start_run();
    in_run = 1'b1;
    cyc('0, 1'b1, "idle_start");
    in_run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    in_clr       = 1'b1;
    in_run       = 1'b0;
    in_ir        = 32'h0;
    in_mem_ready = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(3, "reset_held");
    in_clr = 1'b0;
    idle_cycles(10, "idle_no_run");
    start_run();

    // add r3,r1,r2
    fetch(0);
    in_ir = 32'h1189_0000;
    e = '0; e.loc = 4'd1; e.rf_rd = 1; e.y_wr = 1;            cyc(e, 1'b1, "add_E0");
    e = '0; e.loc = 4'd2; e.rf_rd = 1; e.alu = 4'h0; e.z_wr = 1; cyc(e, 1'b1, "add_E1");
    e = '0; e.loc = 4'd3; e.zl_rd = 1; e.rf_wr = 1;           cyc(e, 1'b1, "add_E2");

    // ld r4,0x10(r2) with three wait cycles on each memory read
    fetch(3);
    in_ir = 32'h0210_0010;
    e = '0; e.loc = 4'd2; e.rf_rd = 1; e.y_wr = 1;            cyc(e, 1'b1, "ld_E0");
    e = '0; e.c_rd = 1; e.alu = 4'h0; e.z_wr = 1;             cyc(e, 1'b1, "ld_E1");
    e = '0; e.zl_rd = 1; e.mar_wr = 1;                        cyc(e, 1'b1, "ld_E2");
    for (int i = 0; i < 3; i++) begin
      e = '0; e.mem_req = 1; e.mdr_sel = 1;                   cyc(e, 1'b0, "ld_E3_wait");
    end
    e = '0; e.mem_req = 1; e.mdr_sel = 1; e.mdr_wr = 1;       cyc(e, 1'b1, "ld_E3_ready");
    e = '0; e.loc = 4'd4; e.mdr_rd = 1; e.rf_wr = 1;          cyc(e, 1'b1, "ld_E4");

    // mul r1,r2
    fetch(0);
    in_ir = 32'h6809_0000;
    e = '0; e.loc = 4'd1; e.rf_rd = 1; e.y_wr = 1;            cyc(e, 1'b1, "mul_E0");
    e = '0; e.loc = 4'd2; e.rf_rd = 1; e.alu = 4'h8; e.z_wr = 1; cyc(e, 1'b1, "mul_E1");
    e = '0; e.zl_rd = 1; e.lo_wr = 1;                         cyc(e, 1'b1, "mul_E2");
    e = '0; e.zh_rd = 1; e.hi_wr = 1;                         cyc(e, 1'b1, "mul_E3");

    // neg r6,r7
    fetch(0);
    in_ir = 32'h7B38_0000;
    e = '0; e.loc = 4'd7; e.rf_rd = 1; e.alu = 4'hA; e.z_wr = 1; cyc(e, 1'b1, "neg_E0");
    e = '0; e.loc = 4'd6; e.zl_rd = 1; e.rf_wr = 1;           cyc(e, 1'b1, "neg_E1");

    // st r5,0x8(r3), aborted by in_clr while the write request is pending
    fetch(0);
    in_ir = 32'h0A98_0008;
    e = '0; e.loc = 4'd3; e.rf_rd = 1; e.y_wr = 1;            cyc(e, 1'b1, "st_E0");
    e = '0; e.c_rd = 1; e.alu = 4'h0; e.z_wr = 1;             cyc(e, 1'b1, "st_E1");
    e = '0; e.zl_rd = 1; e.mar_wr = 1;                        cyc(e, 1'b1, "st_E2");
    e = '0; e.loc = 4'd5; e.rf_rd = 1; e.mdr_wr = 1;          cyc(e, 1'b1, "st_E3");
    e = '0; e.mem_req = 1; e.mem_we = 1;
    cyc(e, 1'b0, "st_E4_wait");
    cyc(e, 1'b0, "st_E4_wait");
    in_mem_ready = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back("st_E4_before_clr");
    @(negedge clk);
    #1;
    in_clr = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(2, "st_abort_clr");
    in_clr = 1'b0;
    idle_cycles(3, "st_abort_idle");

    // undefined opcode, then halt
    start_run();
    fetch(0);
    in_ir = 32'hF800_0000;
    e = '0; e.illegal = 1;                                    cyc(e, 1'b1, "illegal_E0");
    fetch(0);
    in_ir = 32'hA000_0000;
    cyc('0, 1'b1, "halt_E0");
    in_run = 1'b1;
    e = '0; e.halted = 1;
    for (int i = 0; i < 5; i++) cyc(e, 1'b1, "halt_hold");
    in_run = 1'b0;
    in_clr = 1'b1;
    idle_cycles(2, "halt_clr");
    in_clr = 1'b0;
    idle_cycles(2, "after_halt_idle");

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
